// File: rtl/multicycle_control32_pkg.sv
// rtl/multicycle_control32_pkg.sv - shared encodings for the multi-cycle MIPS control FSM
package multicycle_control32_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [2:0] OP_IALU_HI = 3'b001;

    localparam logic [5:0] FN_JR       = 6'b001000;
    localparam logic [2:0] FN_SHIFT_HI = 3'b000;

    typedef enum logic [2:0] {
        ST_RESET  = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        PCSRC_BRANCH = 2'd0,
        PCSRC_JUMP   = 2'd1,
        PCSRC_JR     = 2'd2
    } pcsrc_t;

    // Execute unit reads bit 1 as "arithmetic/logic" and bit 0 as "compare for branch".
    typedef struct packed {
        logic arith;
        logic branch;
    } alu_op_t;

    typedef struct packed {
        logic r_format;
        logic i_format;
        logic lw;
        logic sw;
        logic beq;
        logic bne;
        logic j;
        logic jal;
        logic jr;
        logic sftmd;
        logic illegal;
    } dec_flags_t;

endpackage

// File: rtl/control32_decode.sv
// rtl/control32_decode.sv - combinational opcode/funct to instruction-class flags
module control32_decode
    import multicycle_control32_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output dec_flags_t flags
);

    always_comb begin
        flags          = '0;
        flags.r_format = (opcode == OP_RTYPE);
        flags.i_format = (opcode[5:3] == OP_IALU_HI);
        flags.lw       = (opcode == OP_LW);
        flags.sw       = (opcode == OP_SW);
        flags.beq      = (opcode == OP_BEQ);
        flags.bne      = (opcode == OP_BNE);
        flags.j        = (opcode == OP_J);
        flags.jal      = (opcode == OP_JAL);
        flags.jr       = flags.r_format && (funct == FN_JR);
        flags.sftmd    = flags.r_format && (funct[5:3] == FN_SHIFT_HI);
        flags.illegal  = !(flags.r_format || flags.i_format || flags.lw || flags.sw ||
                           flags.beq || flags.bne || flags.j || flags.jal);
    end

endmodule

// File: rtl/multicycle_control32.sv
// rtl/multicycle_control32.sv - multi-cycle control FSM for the 32-bit MIPS datapath
module multicycle_control32
    import multicycle_control32_pkg::*;
(
    input  logic       clock,
    input  logic       reset_n,
    input  logic [5:0] Opcode_in,
    input  logic [5:0] Function_in,
    input  logic       Zero,
    input  logic       Mem_ready,
    output logic       Inst_req,
    output logic       IRWrite,
    output logic [1:0] ALUOp,
    output logic       ALUSrc,
    output logic       I_format,
    output logic       Sftmd,
    output logic       RegDST,
    output logic       MemtoReg,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       RegWrite,
    output logic       PCWrite,
    output logic [1:0] PCSrc,
    output logic       Jal,
    output logic       Illegal,
    output logic [2:0] State
);

    state_t     state_q, state_d;
    logic [5:0] opcode_q, opcode_d;
    logic [5:0] funct_q, funct_d;
    dec_flags_t dec;
    alu_op_t    alu_op;
    logic       post_exec;

    control32_decode u_decode (
        .opcode (opcode_q),
        .funct  (funct_q),
        .flags  (dec)
    );

    always_comb begin
        state_d  = state_q;
        opcode_d = opcode_q;
        funct_d  = funct_q;
        case (state_q)
            ST_RESET:  state_d = ST_FETCH;
            ST_FETCH: begin
                if (Mem_ready) begin
                    opcode_d = Opcode_in;
                    funct_d  = Function_in;
                    state_d  = ST_DECODE;
                end
            end
            // Illegal opcodes retire as a NOP; PC was already advanced in FETCH.
            ST_DECODE: state_d = dec.illegal ? ST_FETCH : ST_EXEC;
            ST_EXEC: begin
                if (dec.lw || dec.sw)
                    state_d = ST_MEM;
                else if (dec.beq || dec.bne || dec.j || dec.jr)
                    state_d = ST_FETCH;
                else
                    state_d = ST_WB;
            end
            ST_MEM: begin
                if (Mem_ready)
                    state_d = dec.lw ? ST_WB : ST_FETCH;
            end
            ST_WB:     state_d = ST_FETCH;
            default:   state_d = ST_RESET;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_RESET;
            opcode_q <= '0;
            funct_q  <= '0;
        end else begin
            state_q  <= state_d;
            opcode_q <= opcode_d;
            funct_q  <= funct_d;
        end
    end

    assign post_exec = (state_q == ST_EXEC) || (state_q == ST_MEM) || (state_q == ST_WB);

    always_comb begin
        alu_op        = '0;
        alu_op.arith  = dec.r_format || dec.i_format;
        alu_op.branch = dec.beq || dec.bne;

        Inst_req = (state_q == ST_FETCH);
        IRWrite  = (state_q == ST_FETCH) && Mem_ready;
        ALUOp    = post_exec ? alu_op : 2'b00;
        ALUSrc   = post_exec && (dec.i_format || dec.lw || dec.sw);
        I_format = post_exec && dec.i_format;
        Sftmd    = post_exec && dec.sftmd;
        RegDST   = post_exec && dec.r_format;
        MemtoReg = post_exec && dec.lw;
        Jal      = post_exec && dec.jal;
        MemRead  = (state_q == ST_MEM) && dec.lw;
        MemWrite = (state_q == ST_MEM) && dec.sw;
        RegWrite = (state_q == ST_WB);
        Illegal  = (state_q == ST_DECODE) && dec.illegal;
        PCWrite  = 1'b0;
        PCSrc    = PCSRC_BRANCH;
        if (state_q == ST_EXEC) begin
            PCWrite = (dec.beq && Zero) || (dec.bne && !Zero) || dec.j || dec.jal || dec.jr;
            if (dec.jr)
                PCSrc = PCSRC_JR;
            else if (dec.j || dec.jal)
                PCSrc = PCSRC_JUMP;
        end
        State = state_q;
    end

endmodule
